// File: rtl/div_pkg.sv
// Shared types and constants for the 8-bit restoring divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_pkg;

  localparam int DIV_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    SUB   = 3'd3,
    HALT  = 3'd4
  } state_t;

endpackage

// File: rtl/divider_8bit_if.sv
// Operand/result bundle between a requester and divider_8bit.
// Latency: n/a (wires only).
// Backpressure: Run is a level request held until Done; results are held in HALT while Run stays high.
// Signals: Run, Load_Divisor, Din (requester -> divider); Quotient, Remainder, Busy, Done, Div_By_Zero (divider -> requester).
interface divider_8bit_if;
  import div_pkg::*;

  logic                 Run;
  logic                 Load_Divisor;
  logic [DIV_WIDTH-1:0] Din;
  logic [DIV_WIDTH-1:0] Quotient;
  logic [DIV_WIDTH-1:0] Remainder;
  logic                 Busy;
  logic                 Done;
  logic                 Div_By_Zero;

  modport master (
    output Run, Load_Divisor, Din,
    input  Quotient, Remainder, Busy, Done, Div_By_Zero
  );

  modport slave (
    input  Run, Load_Divisor, Din,
    output Quotient, Remainder, Busy, Done, Div_By_Zero
  );

endinterface

// File: rtl/div_control.sv
// Sequencer for the restoring divider: IDLE -> LOAD -> 8 x (SHIFT, SUB) -> HALT, plus the iteration counter.
// Latency: HALT entered 17 edges after LOAD is entered (nonzero divisor), 1 edge for a zero divisor.
// Backpressure: stays in HALT while run is high; returns to IDLE on the first edge with run low.
// Ports: Clk, Reset_n; run, divisor_zero in; idle/load/shift/sub/halt strobes out (decoded from the state register).
module div_control
  import div_pkg::*;
(
  input  logic Clk,
  input  logic Reset_n,
  input  logic run,
  input  logic divisor_zero,
  output logic idle_stb,
  output logic load_stb,
  output logic shift_stb,
  output logic sub_stb,
  output logic halt_stb
);

  state_t     state;
  logic [2:0] count;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      count <= 3'd0;
    end else begin
      case (state)
        IDLE:  if (run) state <= LOAD;
        LOAD: begin
          count <= 3'd0;
          // A zero divisor short-circuits straight to the result state.
          state <= divisor_zero ? HALT : SHIFT;
        end
        SHIFT: state <= SUB;
        SUB: begin
          count <= count + 3'd1;
          state <= (count == 3'd7) ? HALT : SHIFT;
        end
        HALT:  if (!run) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes are pure decodes of the state flop: no input reaches an output combinationally.
  assign idle_stb  = (state == IDLE);
  assign load_stb  = (state == LOAD);
  assign shift_stb = (state == SHIFT);
  assign sub_stb   = (state == SUB);
  assign halt_stb  = (state == HALT);

endmodule

// File: rtl/divider_8bit.sv
// Unsigned 8-bit restoring divider: datapath registers and 9-bit trial subtractor around div_control.
// Latency: Done rises on the 18th edge counting the Run-sampling edge as the 1st (2nd edge for a zero divisor).
// Backpressure: results held in HALT while Run is high; a new division needs Run low then high.
// Ports: Clk, Reset_n (async, active low); bus (slave): Run, Load_Divisor, Din in; Quotient, Remainder, Busy, Done, Div_By_Zero out.
module divider_8bit
  import div_pkg::*;
(
  input  logic           Clk,
  input  logic           Reset_n,
  divider_8bit_if.slave  bus
);

  logic [DIV_WIDTH-1:0] divisor;
  logic [DIV_WIDTH-1:0] quot;
  logic [DIV_WIDTH:0]   rem;      // 9 bits so the shifted-out MSB is never lost
  logic                 dbz;
  logic [DIV_WIDTH+1:0] diff;     // extra top bit is the borrow
  logic                 borrow;

  logic idle_stb, load_stb, shift_stb, sub_stb, halt_stb;

  div_control u_ctrl (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .run          (bus.Run),
    .divisor_zero (divisor == '0),
    .idle_stb     (idle_stb),
    .load_stb     (load_stb),
    .shift_stb    (shift_stb),
    .sub_stb      (sub_stb),
    .halt_stb     (halt_stb)
  );

  assign diff   = {1'b0, rem} - {2'b00, divisor};
  assign borrow = diff[DIV_WIDTH+1];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      divisor <= '0;
      quot    <= '0;
      rem     <= '0;
      dbz     <= 1'b0;
    end else begin
      // Divisor only capturable while idle; same-edge Run is fine since LOAD reads it next cycle.
      if (idle_stb && bus.Load_Divisor) divisor <= bus.Din;

      if (load_stb) begin
        if (divisor == '0) begin
          quot <= '1;
          rem  <= {1'b0, bus.Din};
          dbz  <= 1'b1;
        end else begin
          quot <= bus.Din;
          rem  <= '0;
          dbz  <= 1'b0;
        end
      end

      if (shift_stb) begin
        rem  <= {rem[DIV_WIDTH-1:0], quot[DIV_WIDTH-1]};
        quot <= {quot[DIV_WIDTH-2:0], 1'b0};
      end

      // Restoring step: keep the difference only when it did not go negative.
      if (sub_stb && !borrow) begin
        rem     <= diff[DIV_WIDTH:0];
        quot[0] <= 1'b1;
      end
    end
  end

  assign bus.Quotient    = quot;
  assign bus.Remainder   = rem[DIV_WIDTH-1:0];
  assign bus.Busy        = load_stb | shift_stb | sub_stb;
  assign bus.Done        = halt_stb;
  assign bus.Div_By_Zero = dbz;

endmodule

// File: tb/tb_divider_8bit.sv
// Self-checking bench for divider_8bit: vector table plus hand-written corner sequences,
// expected results queued on the scoreboard at Run and popped when Done appears.
// Edge numbering: the edge that first samples Run high is edge 1.
module tb_divider_8bit;

  logic Clk;
  logic Reset_n;

  divider_8bit_if bus ();

  divider_8bit dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
  } exp_t;

  typedef struct {
    logic [7:0] dvs;
    logic [7:0] dvd;
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    int         lat;
  } vec_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // One full division: optional divisor load, Run high until Done, compare, then Run low.
  task automatic do_div(input logic [7:0] dvs, input logic [7:0] dvd, input bit load,
                        input bit noise, input exp_t e, input int lat, input string tag);
    int   cyc;
    bit   got;
    exp_t p;
    if (load) begin
      @(negedge Clk);
      bus.Load_Divisor = 1'b1;
      bus.Din          = dvs;
    end
    @(negedge Clk);
    bus.Load_Divisor = 1'b0;
    bus.Din          = dvd;
    bus.Run          = 1'b1;
    sb.push_back(e);
    cyc = 0;
    got = 1'b0;
    while (cyc < 40 && !got) begin
      @(negedge Clk);
      cyc++;
      if (bus.Done) got = 1'b1;
      else begin
        if (cyc == 1) chk({tag, " busy_in_load"}, bus.Busy, 1);
        // After LOAD has consumed the dividend, bus activity must not matter.
        if (cyc >= 2) begin
          bus.Din = 8'($urandom);
          if (noise) begin
            bus.Load_Divisor = ~bus.Load_Divisor;
            if (bus.Load_Divisor) bus.Din = 8'd1;
          end
        end
      end
    end
    bus.Load_Divisor = 1'b0;
    if (!got) $display("FAIL %s timeout: got no Done within %0d edges required at edge %0d", tag, cyc, lat);
    chk({tag, " done_edge"}, cyc, lat);
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s scoreboard: got empty queue required one entry", tag);
    end else begin
      p = sb.pop_front();
      chk({tag, " quotient"},  bus.Quotient,    p.q);
      chk({tag, " remainder"}, bus.Remainder,   p.r);
      chk({tag, " dbz"},       bus.Div_By_Zero, p.dbz);
      chk({tag, " busy_halt"}, bus.Busy,        0);
    end
    bus.Run = 1'b0;
    @(negedge Clk);
    chk({tag, " done_idle"}, bus.Done,     0);
    chk({tag, " q_held"},    bus.Quotient, e.q);
  endtask

  vec_t vecs[9];

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got no finish by 300us required earlier finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    exp_t e;
    int   done_cnt;
    int   busy_cnt;
    int   first_done;

    vecs[0] = '{8'd7,   8'd200, 8'd28,  8'd4,  1'b0, 18};
    vecs[1] = '{8'd1,   8'd255, 8'd255, 8'd0,  1'b0, 18};
    vecs[2] = '{8'd255, 8'd255, 8'd1,   8'd0,  1'b0, 18};
    vecs[3] = '{8'd10,  8'd5,   8'd0,   8'd5,  1'b0, 18};
    vecs[4] = '{8'd0,   8'd9,   8'hFF,  8'd9,  1'b1, 2};
    vecs[5] = '{8'd3,   8'd100, 8'd33,  8'd1,  1'b0, 18};
    vecs[6] = '{8'd13,  8'd0,   8'd0,   8'd0,  1'b0, 18};
    vecs[7] = '{8'd16,  8'd255, 8'd15,  8'd15, 1'b0, 18};
    vecs[8] = '{8'd2,   8'd129, 8'd64,  8'd1,  1'b0, 18};

    // Reset values, checked before any clock edge.
    Reset_n          = 1'b0;
    bus.Run          = 1'b0;
    bus.Load_Divisor = 1'b0;
    bus.Din          = 8'd0;
    #3;
    chk("rst quotient",  bus.Quotient,    0);
    chk("rst remainder", bus.Remainder,   0);
    chk("rst busy",      bus.Busy,        0);
    chk("rst done",      bus.Done,        0);
    chk("rst dbz",       bus.Div_By_Zero, 0);
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;

    // Vector table; Load_Divisor/Din are toggled during SHIFT/SUB to show they are ignored.
    for (int i = 0; i < 9; i++) begin
      e = '{vecs[i].q, vecs[i].r, vecs[i].dbz};
      do_div(vecs[i].dvs, vecs[i].dvd, 1'b1, 1'b1, e, vecs[i].lat, $sformatf("vec%0d", i));
    end

    // Run held high for 40 edges: exactly one division, HALT held throughout.
    @(negedge Clk);
    bus.Load_Divisor = 1'b1;
    bus.Din          = 8'd7;
    @(negedge Clk);
    bus.Load_Divisor = 1'b0;
    bus.Din          = 8'd200;
    bus.Run          = 1'b1;
    done_cnt   = 0;
    busy_cnt   = 0;
    first_done = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge Clk);
      if (bus.Done) begin
        done_cnt++;
        if (first_done == 0) first_done = c;
      end
      if (bus.Busy) busy_cnt++;
      if (c >= 2) bus.Din = 8'($urandom);
    end
    chk("hold first_done", first_done,   18);
    chk("hold done_cnt",   done_cnt,     23);
    chk("hold busy_cnt",   busy_cnt,     17);
    chk("hold quotient",   bus.Quotient, 28);
    chk("hold remainder",  bus.Remainder, 4);
    bus.Run = 1'b0;
    @(negedge Clk);
    chk("hold idle_done",  bus.Done,     0);
    chk("hold idle_busy",  bus.Busy,     0);
    chk("hold idle_q",     bus.Quotient, 28);
    // Second division with the retained divisor 7: 100/7 = 14 r 2.
    e = '{8'd14, 8'd2, 1'b0};
    do_div(8'd0, 8'd100, 1'b0, 1'b0, e, 18, "retained");

    // Reset pulsed mid-cycle during SUB of iteration 4 (state entered at edge 11).
    @(negedge Clk);
    bus.Load_Divisor = 1'b1;
    bus.Din          = 8'd9;
    @(negedge Clk);
    bus.Load_Divisor = 1'b0;
    bus.Din          = 8'd200;
    bus.Run          = 1'b1;
    for (int c = 1; c <= 11; c++) @(negedge Clk);
    chk("abort busy_before", bus.Busy, 1);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("abort quotient",  bus.Quotient,    0);
    chk("abort remainder", bus.Remainder,   0);
    chk("abort busy",      bus.Busy,        0);
    chk("abort done",      bus.Done,        0);
    chk("abort dbz",       bus.Div_By_Zero, 0);
    bus.Run = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    e = '{8'd33, 8'd1, 1'b0};
    do_div(8'd3, 8'd100, 1'b1, 1'b0, e, 18, "post_reset");

    // Divisor reload attempts throughout SHIFT/SUB must not disturb 200/7.
    e = '{8'd28, 8'd4, 1'b0};
    do_div(8'd7, 8'd200, 1'b1, 1'b1, e, 18, "ld_noise");

    chk("scoreboard drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/divider_8bit.md
DIVIDER_8BIT -- requirements
Module: divider_8bit

Interface
REQ-001 SHALL have port Clk  input  1  single system clock; all state changes on its rising edge.
REQ-002 SHALL have port Reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port Run  input  1  level request to start one division.
REQ-004 SHALL have port Load_Divisor  input  1  captures Din into the divisor register.
REQ-005 SHALL have port Din  input  8  unsigned operand bus: divisor on Load_Divisor, dividend on start.
REQ-006 SHALL have port Quotient  output  8  quotient register.
REQ-007 SHALL have port Remainder  output  8  low 8 bits of the partial-remainder register.
REQ-008 SHALL have port Busy  output  1  high in LOAD, SHIFT and SUB.
REQ-009 SHALL have port Done  output  1  high in HALT only.
REQ-010 SHALL have port Div_By_Zero  output  1  sticky flag, valid while Done is high.

Function
REQ-011 SHALL implement an unsigned 8-bit restoring divider with an FSM of states IDLE, LOAD, SHIFT, SUB, HALT.
REQ-012 SHALL, in IDLE with Load_Divisor high, capture Din into the divisor on the next edge; in all other states Load_Divisor is ignored.
REQ-013 SHALL leave IDLE for LOAD on the first edge where Run is high; Load_Divisor and Run both high in IDLE: divisor captured and LOAD entered on the same edge.
REQ-014 SHALL, in LOAD, set Quotient to Din (dividend), the 9-bit partial remainder to 0, the 3-bit iteration counter to 0 and Div_By_Zero to 0.
REQ-015 SHALL, in LOAD with divisor equal to 0, go directly to HALT with Div_By_Zero=1, Quotient=8'hFF, Remainder=dividend.
REQ-016 SHALL, in LOAD with a nonzero divisor, go to SHIFT.
REQ-017 SHALL, in SHIFT, shift {remainder, Quotient} left one bit; Quotient bit 0 becomes 0; the remainder holds 9 bits, so no bit is lost.
REQ-018 SHALL, in SUB, form remainder minus the zero-extended divisor at 9 bits.
REQ-019 SHALL, in SUB, when that difference is non-negative, write the difference back to the remainder and set Quotient bit 0 to 1; otherwise the remainder is unchanged and Quotient bit 0 stays 0.
REQ-020 SHALL, in SUB, increment the counter and go to SHIFT, or go to HALT when the counter was 7; there are exactly 8 SHIFT/SUB pairs.
REQ-021 SHALL assert Done exactly 18 edges after the edge on which Run was first sampled high in IDLE (nonzero divisor), and 2 edges after it for a zero divisor.
REQ-022 SHALL remain in HALT with results held while Run is high, and return to IDLE on the first edge with Run low; a new division requires Run to go low and then high again.
REQ-023 SHALL ignore Run and Din changes during LOAD (after capture), SHIFT and SUB.
REQ-024 SHALL keep Quotient and Remainder unchanged in IDLE and HALT.
REQ-025 SHALL drive Busy, Done and Div_By_Zero as registered-state decodes, with no combinational path from any input to any output.

Reset
REQ-026 SHALL, on Reset_n low and regardless of Clk, force state IDLE and clear Quotient, the remainder, the divisor, the counter and Div_By_Zero to 0; Busy=0, Done=0.
REQ-027 SHALL, when reset is asserted mid-division, abort the division with no partial result retained; after release the next division starts from IDLE.
REQ-028 SHALL begin normal operation on the first rising Clk edge after Reset_n goes high.

Structure
REQ-029 SHALL place the state enum (IDLE, LOAD, SHIFT, SUB, HALT) and the constant DIV_WIDTH=8 in shared package div_pkg.
REQ-030 SHALL split the FSM and counter into sub-module div_control, which emits load/shift/sub/halt strobes; the datapath registers and 9-bit subtractor stay in divider_8bit.

Verification
REQ-031 SHALL cover: divisor 7, dividend 200 -> Done at edge 18, Quotient=28, Remainder=4, Div_By_Zero=0.
REQ-032 SHALL cover: divisor 1, dividend 255 -> Quotient=255, Remainder=0; divisor 255, dividend 255 -> Quotient=1, Remainder=0.
REQ-033 SHALL cover: divisor 10, dividend 5 -> Quotient=0, Remainder=5; divisor 0, dividend 9 -> Done at edge 2, Div_By_Zero=1, Quotient=8'hFF, Remainder=9.
REQ-034 SHALL cover: Run held high 40 cycles -> one division only, HALT held; Run low -> IDLE next edge; Run high again -> second division with the retained divisor.
REQ-035 SHALL cover: Reset_n pulsed low mid-cycle during SUB of iteration 4 -> outputs zero immediately, state IDLE, Busy=0; a subsequent 100/3 gives Quotient=33, Remainder=1.
REQ-036 SHALL cover: Load_Divisor toggled with new Din during SHIFT/SUB -> result still uses the original divisor.
